// File: rtl/cplx_arith_unit.sv
// Registered complex multiply (scaled by an arithmetic right shift) and complex add.
// The real and imaginary components each saturate to W bits on their own; latency is one cycle.
module cplx_arith_unit #(
    parameter int W   = 16,
    parameter int SHW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2*W-1:0]   mul_opa,
    input  logic [2*W-1:0]   mul_opb,
    input  logic [SHW-1:0]   shift,
    input  logic [2*W-1:0]   add_opa,
    input  logic [2*W-1:0]   add_opb,
    output logic [2*W-1:0]   mul_out,
    output logic [2*W-1:0]   add_out,
    output logic             out_valid
);

    localparam int PW = 2*W + 1;

    // Fits in W bits only when the bits from the top down to W-1 are all copies of the sign.
    function automatic logic [W-1:0] sat_w(input logic signed [PW-1:0] x);
        logic [PW-W:0] upper;
        upper = x[PW-1:W-1];
        if ((upper == {(PW-W+1){1'b0}}) || (upper == {(PW-W+1){1'b1}})) begin
            sat_w = x[W-1:0];
        end else if (x[PW-1]) begin
            sat_w = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_w = {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    logic signed [W-1:0]   mar_s, mai_s, mbr_s, mbi_s;
    logic signed [W-1:0]   aar_s, aai_s, abr_s, abi_s;
    logic signed [2*W-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;
    logic signed [PW-1:0]  pr_s, pi_s, pr_sh_s, pi_sh_s;
    logic signed [W:0]     sr_s, si_s;
    logic [2*W-1:0]        mul_d, mul_q;
    logic [2*W-1:0]        add_d, add_q;
    logic                  valid_d, valid_q;

    // Full-precision complex product, scaling and saturation for both datapaths.
    always_comb begin
        mar_s = mul_opa[2*W-1:W];
        mai_s = mul_opa[W-1:0];
        mbr_s = mul_opb[2*W-1:W];
        mbi_s = mul_opb[W-1:0];
        aar_s = add_opa[2*W-1:W];
        aai_s = add_opa[W-1:0];
        abr_s = add_opb[2*W-1:W];
        abi_s = add_opb[W-1:0];

        // Each W x W product is exact in 2W bits; the sum/difference needs one more.
        p_rr_s = (2*W)'(mar_s) * (2*W)'(mbr_s);
        p_ii_s = (2*W)'(mai_s) * (2*W)'(mbi_s);
        p_ri_s = (2*W)'(mar_s) * (2*W)'(mbi_s);
        p_ir_s = (2*W)'(mai_s) * (2*W)'(mbr_s);
        pr_s   = PW'(p_rr_s) - PW'(p_ii_s);
        pi_s   = PW'(p_ri_s) + PW'(p_ir_s);

        // Arithmetic shift sign-fills, so oversized shifts settle at 0 or -1.
        pr_sh_s = pr_s >>> shift;
        pi_sh_s = pi_s >>> shift;

        sr_s = {aar_s[W-1], aar_s} + {abr_s[W-1], abr_s};
        si_s = {aai_s[W-1], aai_s} + {abi_s[W-1], abi_s};

        mul_d   = {sat_w(pr_sh_s), sat_w(pi_sh_s)};
        add_d   = {sat_w(PW'(sr_s)), sat_w(PW'(si_s))};
        valid_d = in_valid;
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_q   <= {(2*W){1'b0}};
            add_q   <= {(2*W){1'b0}};
            valid_q <= 1'b0;
        end else begin
            mul_q   <= mul_d;
            add_q   <= add_d;
            valid_q <= valid_d;
        end
    end

    assign mul_out   = mul_q;
    assign add_out   = add_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cplx_arith_unit.sv
// Directed and randomized bench for cplx_arith_unit against an integer-arithmetic reference model.
module tb_cplx_arith_unit;

    localparam int W   = 16;
    localparam int SHW = 5;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [2*W-1:0] mul_opa, mul_opb, add_opa, add_opb;
    logic [SHW-1:0] shift;
    logic [2*W-1:0] mul_out, add_out;
    logic           out_valid;

    int checks   = 0;
    int failures = 0;

    cplx_arith_unit #(.W(W), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mul_opa   (mul_opa),
        .mul_opb   (mul_opb),
        .shift     (shift),
        .add_opa   (add_opa),
        .add_opb   (add_opb),
        .mul_out   (mul_out),
        .add_out   (add_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cpx(input int re, input int im);
        logic [31:0] r, i;
        r = re;
        i = im;
        return {r[15:0], i[15:0]};
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        logic [63:0] u;
        u = v;
        if (v > 64'sd32767)       return 16'h7fff;
        else if (v < -64'sd32768) return 16'h8000;
        else                      return u[15:0];
    endfunction

    function automatic longint re_of(input logic [31:0] c);
        logic signed [15:0] t;
        t = c[31:16];
        return longint'(t);
    endfunction

    function automatic longint im_of(input logic [31:0] c);
        logic signed [15:0] t;
        t = c[15:0];
        return longint'(t);
    endfunction

    // Reference: exact integer products, floor division by 2**sh, then clamp.
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b, input int sh);
        longint pr, pi;
        pr = re_of(a) * re_of(b) - im_of(a) * im_of(b);
        pi = re_of(a) * im_of(b) + im_of(a) * re_of(b);
        pr = pr >>> sh;
        pi = pi >>> sh;
        return {sat16(pr), sat16(pi)};
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        return {sat16(re_of(a) + re_of(b)), sat16(im_of(a) + im_of(b))};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check3(input string tag, input logic [31:0] em, input logic [31:0] ea, input logic ev);
        checks++;
        assert (mul_out === em) else begin
            failures++;
            $error("FAIL %s mul_out got=%h exp=%h", tag, mul_out, em);
        end
        checks++;
        assert (add_out === ea) else begin
            failures++;
            $error("FAIL %s add_out got=%h exp=%h", tag, add_out, ea);
        end
        checks++;
        assert (out_valid === ev) else begin
            failures++;
            $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, ev);
        end
    endtask

    // Apply one operand set, clock it, and compare against the model one cycle later.
    task automatic step(input string tag, input logic v, input logic [31:0] ma, input logic [31:0] mb,
                        input int sh, input logic [31:0] aa, input logic [31:0] ab);
        logic [31:0] em, ea;
        in_valid = v;
        mul_opa  = ma;
        mul_opb  = mb;
        shift    = SHW'(sh);
        add_opa  = aa;
        add_opb  = ab;
        em = model_mul(ma, mb, sh);
        ea = model_add(aa, ab);
        @(posedge clk);
        #1;
        check3(tag, em, ea, v);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mul_opa  = cpx(3, 4);
        mul_opb  = cpx(1, 2);
        shift    = 5'd0;
        add_opa  = cpx(100, -5);
        add_opb  = cpx(-50, 7);
        repeat (2) @(posedge clk);
        #1;
        check3("reset", 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;

        // Test-plan vectors; constants double as a check on the model itself.
        step("basic", 1'b1, cpx(3, 4), cpx(1, 2), 0, cpx(100, -5), cpx(-50, 7));
        checks++;
        assert (mul_out === cpx(-5, 10) && add_out === cpx(50, 2)) else begin
            failures++;
            $error("FAIL basic_const mul=%h add=%h", mul_out, add_out);
        end
        step("shift1", 1'b1, cpx(3, 4), cpx(1, 2), 1, cpx(0, 0), cpx(0, 0));
        checks++;
        assert (mul_out === cpx(-3, 5)) else begin
            failures++;
            $error("FAIL shift1_const got=%h exp=%h", mul_out, cpx(-3, 5));
        end
        step("shift4", 1'b1, cpx(3, 4), cpx(1, 2), 4, cpx(0, 0), cpx(0, 0));
        checks++;
        assert (mul_out === cpx(-1, 0)) else begin
            failures++;
            $error("FAIL shift4_const got=%h exp=%h", mul_out, cpx(-1, 0));
        end
        step("sat_pp", 1'b1, cpx(32767, 0), cpx(32767, 0), 0, cpx(30000, -30000), cpx(30000, -30000));
        checks++;
        assert (mul_out === cpx(32767, 0) && add_out === cpx(32767, -32768)) else begin
            failures++;
            $error("FAIL sat_pp_const mul=%h add=%h", mul_out, add_out);
        end
        step("sat_nn", 1'b1, cpx(-32768, 0), cpx(-32768, 0), 0, cpx(0, 0), cpx(0, 0));
        checks++;
        assert (mul_out === cpx(32767, 0)) else begin
            failures++;
            $error("FAIL sat_nn_const got=%h exp=%h", mul_out, cpx(32767, 0));
        end
        step("shift30", 1'b1, cpx(-32768, 0), cpx(-32768, 0), 30, cpx(0, 0), cpx(0, 0));
        checks++;
        assert (mul_out === cpx(1, 0)) else begin
            failures++;
            $error("FAIL shift30_const got=%h exp=%h", mul_out, cpx(1, 0));
        end
        step("sat_neg", 1'b1, cpx(-32768, 0), cpx(32767, 0), 0, cpx(0, 0), cpx(0, 0));
        checks++;
        assert (mul_out === cpx(-32768, 0)) else begin
            failures++;
            $error("FAIL sat_neg_const got=%h exp=%h", mul_out, cpx(-32768, 0));
        end
        step("shift31", 1'b1, cpx(-32768, 32767), cpx(32767, 32767), 31, cpx(-1, 1), cpx(1, -1));

        // Pipeline with valid pattern 1,0,1.
        step("pipe0", 1'b1, cpx(10, -20), cpx(7, 3), 2, cpx(1, 2), cpx(3, 4));
        step("pipe1", 1'b0, cpx(-300, 400), cpx(50, -60), 0, cpx(-7, 8), cpx(9, -10));
        step("pipe2", 1'b1, cpx(1234, 5678), cpx(-8, 9), 3, cpx(20000, -20000), cpx(20000, -20000));

        // Reset mid-stream discards the in-flight result.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mul_opa  = cpx(3, 4);
        mul_opb  = cpx(1, 2);
        add_opa  = cpx(5, 5);
        add_opb  = cpx(5, 5);
        @(posedge clk);
        #1;
        check3("midreset", 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        step("resume", 1'b1, cpx(3, 4), cpx(1, 2), 0, cpx(100, -5), cpx(-50, 7));

        // Randomized vectors biased toward the saturation corners.
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom), {rnd16(), rnd16()}, {rnd16(), rnd16()},
                 int'($urandom_range(0, 31)), {rnd16(), rnd16()}, {rnd16(), rnd16()});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
